// File: rtl/mrv1_th_ibuf.sv
// Per-thread instruction buffer between fetch and the issue-stage thread selector.
// Each hardware thread owns a small FIFO; the selector reads issue_rdy_o and pops one thread per cycle.
module mrv1_th_ibuf #(
   parameter int NUM_THREADS_P    = 8,
   parameter int DEPTH_P          = 2,
   parameter int INSTR_WIDTH_P    = 32,
   parameter int PC_WIDTH_P       = 32,
   parameter bit CHECK_SELECTOR_P = 1'b1,
   localparam int TID_WIDTH_LP    = $clog2(NUM_THREADS_P),
   localparam int CNT_WIDTH_LP    = $clog2(DEPTH_P + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     fetch_vld_i,
   input  logic [TID_WIDTH_LP-1:0]  fetch_tid_i,
   input  logic [INSTR_WIDTH_P-1:0] fetch_instr_i,
   input  logic [PC_WIDTH_P-1:0]    fetch_pc_i,
   output logic [NUM_THREADS_P-1:0] fetch_rdy_o,
   input  logic [NUM_THREADS_P-1:0] stall_i,
   input  logic [NUM_THREADS_P-1:0] flush_i,
   output logic [NUM_THREADS_P-1:0] issue_rdy_o,
   input  logic                     issue_vld_i,
   input  logic [TID_WIDTH_LP-1:0]  issue_tid_i,
   output logic [INSTR_WIDTH_P-1:0] issue_instr_o,
   output logic [PC_WIDTH_P-1:0]    issue_pc_o
);

   localparam int PTR_WIDTH_LP = $clog2(DEPTH_P);
   localparam logic [CNT_WIDTH_LP-1:0] FULL_CNT_LP = CNT_WIDTH_LP'(DEPTH_P);

   logic [CNT_WIDTH_LP-1:0]  count_q  [NUM_THREADS_P];
   logic [PTR_WIDTH_LP-1:0]  wr_ptr_q [NUM_THREADS_P];
   logic [PTR_WIDTH_LP-1:0]  rd_ptr_q [NUM_THREADS_P];
   logic [INSTR_WIDTH_P-1:0] instr_mem [NUM_THREADS_P][DEPTH_P];
   logic [PC_WIDTH_P-1:0]    pc_mem    [NUM_THREADS_P][DEPTH_P];

   logic [NUM_THREADS_P-1:0] push;
   logic [NUM_THREADS_P-1:0] pop;

   // Readiness comes only from registered occupancy plus live hazards, so there is no fetch-to-issue bypass.
   always_comb begin
      fetch_rdy_o = '0;
      issue_rdy_o = '0;
      for (int t = 0; t < NUM_THREADS_P; t++) begin
         fetch_rdy_o[t] = (count_q[t] != FULL_CNT_LP);
         issue_rdy_o[t] = (count_q[t] != '0) && !stall_i[t] && !flush_i[t];
      end
   end

   always_comb begin
      push = '0;
      pop  = '0;
      for (int t = 0; t < NUM_THREADS_P; t++) begin
         push[t] = fetch_vld_i && (fetch_tid_i == TID_WIDTH_LP'(t)) &&
                   fetch_rdy_o[t] && !flush_i[t];
         pop[t]  = issue_vld_i && (issue_tid_i == TID_WIDTH_LP'(t)) && issue_rdy_o[t];
      end
   end

   always_comb begin
      issue_instr_o = '0;
      issue_pc_o    = '0;
      if (count_q[issue_tid_i] != '0) begin
         issue_instr_o = instr_mem[issue_tid_i][rd_ptr_q[issue_tid_i]];
         issue_pc_o    = pc_mem[issue_tid_i][rd_ptr_q[issue_tid_i]];
      end
   end

   // Storage carries no reset; entries are only visible once count says they are valid.
   always_ff @(posedge clk_i) begin
      for (int t = 0; t < NUM_THREADS_P; t++) begin
         if (push[t]) begin
            instr_mem[t][wr_ptr_q[t]] <= fetch_instr_i;
            pc_mem[t][wr_ptr_q[t]]    <= fetch_pc_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int t = 0; t < NUM_THREADS_P; t++) begin
            count_q[t]  <= '0;
            wr_ptr_q[t] <= '0;
            rd_ptr_q[t] <= '0;
         end
      end else begin
         for (int t = 0; t < NUM_THREADS_P; t++) begin
            if (flush_i[t]) begin
               count_q[t]  <= '0;
               wr_ptr_q[t] <= '0;
               rd_ptr_q[t] <= '0;
            end else begin
               if (push[t]) wr_ptr_q[t] <= wr_ptr_q[t] + PTR_WIDTH_LP'(1);
               if (pop[t])  rd_ptr_q[t] <= rd_ptr_q[t] + PTR_WIDTH_LP'(1);
               case ({push[t], pop[t]})
                  2'b10:   count_q[t] <= count_q[t] + CNT_WIDTH_LP'(1);
                  2'b01:   count_q[t] <= count_q[t] - CNT_WIDTH_LP'(1);
                  default: count_q[t] <= count_q[t];
               endcase
            end
         end
      end
   end

   // Occupancy/pointer consistency; the selector check can be disabled for benches that probe ignored pops.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int t = 0; t < NUM_THREADS_P; t++) begin
            assert (count_q[t] <= FULL_CNT_LP);
            assert (PTR_WIDTH_LP'(wr_ptr_q[t] - rd_ptr_q[t]) == count_q[t][PTR_WIDTH_LP-1:0]);
         end
         if (CHECK_SELECTOR_P) begin
            assert (!issue_vld_i || issue_rdy_o[issue_tid_i]);
         end
      end
   end

endmodule

// File: tb/tb_mrv1_th_ibuf.sv
// Self-checking bench for mrv1_th_ibuf: a directed vector table plus scoreboard-driven
// wrap-around, round-robin selector and mid-sequence reset sequences.
module tb_mrv1_th_ibuf;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        fetch_vld;
   logic [2:0]  fetch_tid;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
   logic [7:0]  fetch_rdy;
   logic [7:0]  stall;
   logic [7:0]  flush;
   logic [7:0]  issue_rdy;
   logic        issue_vld;
   logic [2:0]  issue_tid;
   logic [31:0] issue_instr;
   logic [31:0] issue_pc;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        fv;
      logic [2:0]  ftid;
      logic [31:0] finstr;
      logic [31:0] fpc;
      logic [7:0]  stall;
      logic [7:0]  flush;
      logic        iv;
      logic [2:0]  itid;
      logic [7:0]  exp_frdy;
      logic [7:0]  exp_irdy;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
   } vec_t;

   typedef struct packed {
      logic [2:0]  tid;
      logic [31:0] instr;
      logic [31:0] pc;
   } sb_t;

   vec_t vecs[16];
   sb_t  sb_q[$];
   int   rr_ptr = 0;

   mrv1_th_ibuf #(
      .NUM_THREADS_P(8),
      .DEPTH_P(2),
      .INSTR_WIDTH_P(32),
      .PC_WIDTH_P(32),
      .CHECK_SELECTOR_P(1'b0)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .fetch_vld_i(fetch_vld),
      .fetch_tid_i(fetch_tid),
      .fetch_instr_i(fetch_instr),
      .fetch_pc_i(fetch_pc),
      .fetch_rdy_o(fetch_rdy),
      .stall_i(stall),
      .flush_i(flush),
      .issue_rdy_o(issue_rdy),
      .issue_vld_i(issue_vld),
      .issue_tid_i(issue_tid),
      .issue_instr_o(issue_instr),
      .issue_pc_o(issue_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t make_vec(logic fv, logic [2:0] ftid, logic [31:0] fi, logic [31:0] fp,
                                     logic [7:0] st, logic [7:0] fl, logic iv, logic [2:0] itid,
                                     logic [7:0] efr, logic [7:0] eir, logic [31:0] ei, logic [31:0] ep);
      vec_t v;
      v.fv = fv; v.ftid = ftid; v.finstr = fi; v.fpc = fp;
      v.stall = st; v.flush = fl; v.iv = iv; v.itid = itid;
      v.exp_frdy = efr; v.exp_irdy = eir; v.exp_instr = ei; v.exp_pc = ep;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      fetch_vld   = v.fv;
      fetch_tid   = v.ftid;
      fetch_instr = v.finstr;
      fetch_pc    = v.fpc;
      stall       = v.stall;
      flush       = v.flush;
      issue_vld   = v.iv;
      issue_tid   = v.itid;
   endtask

   task automatic drive_idle(input logic [2:0] itid);
      apply_stimulus(make_vec(0, 0, 0, 0, 8'h00, 8'h00, 0, itid, 0, 0, 0, 0));
   endtask

   function automatic logic [7:0] model_rdy();
      logic [7:0] r = 8'h00;
      foreach (sb_q[i]) r[sb_q[i].tid] = 1'b1;
      return r;
   endfunction

   task automatic drive_push(input logic [2:0] tid, input logic [31:0] instr, input logic [31:0] pc,
                             input logic iv, input logic [2:0] itid);
      apply_stimulus(make_vec(1, tid, instr, pc, 8'h00, 8'h00, iv, itid, 0, 0, 0, 0));
      sb_q.push_back('{tid: tid, instr: instr, pc: pc});
   endtask

   task automatic sb_pop_check(input logic [2:0] tid);
      int idx = -1;
      for (int i = 0; i < sb_q.size(); i++) begin
         if (idx < 0 && sb_q[i].tid == tid) idx = i;
      end
      if (idx < 0) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL sb_empty: tid %0d popped with no expected entry", tid);
      end else begin
         check_output($sformatf("pop_instr_t%0d", tid), {32'h0, issue_instr}, {32'h0, sb_q[idx].instr});
         check_output($sformatf("pop_pc_t%0d", tid), {32'h0, issue_pc}, {32'h0, sb_q[idx].pc});
         sb_q.delete(idx);
      end
   endtask

   task automatic push_all(input logic [31:0] base);
      for (int t = 0; t < 8; t++) begin
         @(posedge clk); #1;
         drive_push(3'(t), base + 32'(t), 32'h400 + 32'(4 * t), 0, 0);
      end
   endtask

   task automatic rr_pop(input int n);
      for (int k = 0; k < n; k++) begin
         int sel = -1;
         @(posedge clk); #1;
         drive_idle(0);
         for (int j = 0; j < 8; j++) begin
            int c = (rr_ptr + j) % 8;
            if (sel < 0 && issue_rdy[c]) sel = c;
         end
         if (sel < 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL selector_timeout: issue_rdy %h, expected %h", issue_rdy, model_rdy());
         end else begin
            issue_vld = 1'b1;
            issue_tid = 3'(sel);
            rr_ptr    = (sel + 1) % 8;
            @(negedge clk);
            check_output("rr_rdy", {56'h0, issue_rdy}, {56'h0, model_rdy()});
            sb_pop_check(3'(sel));
         end
      end
   endtask

   initial begin
      vecs[0]  = make_vec(0, 0, 0, 0,                 8'h00, 8'h00, 0, 0, 8'hFF, 8'h00, 32'h0,  32'h0);
      vecs[1]  = make_vec(1, 3, 32'hA1, 32'h100,      8'h00, 8'h00, 0, 3, 8'hFF, 8'h00, 32'h0,  32'h0);
      vecs[2]  = make_vec(0, 0, 0, 0,                 8'h00, 8'h00, 1, 3, 8'hFF, 8'h08, 32'hA1, 32'h100);
      vecs[3]  = make_vec(0, 0, 0, 0,                 8'h00, 8'h00, 0, 3, 8'hFF, 8'h00, 32'h0,  32'h0);
      vecs[4]  = make_vec(1, 5, 32'hB0, 32'h200,      8'h00, 8'h00, 0, 5, 8'hFF, 8'h00, 32'h0,  32'h0);
      vecs[5]  = make_vec(1, 5, 32'hB1, 32'h204,      8'h00, 8'h00, 0, 5, 8'hFF, 8'h20, 32'hB0, 32'h200);
      vecs[6]  = make_vec(1, 5, 32'hB2, 32'h208,      8'h00, 8'h00, 0, 5, 8'hDF, 8'h20, 32'hB0, 32'h200);
      vecs[7]  = make_vec(0, 0, 0, 0,                 8'h00, 8'h00, 1, 5, 8'hDF, 8'h20, 32'hB0, 32'h200);
      vecs[8]  = make_vec(0, 0, 0, 0,                 8'h00, 8'h00, 1, 5, 8'hFF, 8'h20, 32'hB1, 32'h204);
      vecs[9]  = make_vec(0, 0, 0, 0,                 8'h00, 8'h00, 0, 5, 8'hFF, 8'h00, 32'h0,  32'h0);
      vecs[10] = make_vec(1, 1, 32'hC0, 32'h300,      8'h00, 8'h00, 0, 1, 8'hFF, 8'h00, 32'h0,  32'h0);
      vecs[11] = make_vec(1, 1, 32'hC1, 32'h304,      8'h00, 8'h00, 0, 1, 8'hFF, 8'h02, 32'hC0, 32'h300);
      vecs[12] = make_vec(0, 0, 0, 0,                 8'h02, 8'h00, 1, 1, 8'hFD, 8'h00, 32'hC0, 32'h300);
      vecs[13] = make_vec(0, 0, 0, 0,                 8'h02, 8'h00, 0, 1, 8'hFD, 8'h00, 32'hC0, 32'h300);
      vecs[14] = make_vec(1, 1, 32'hC2, 32'h308,      8'h00, 8'h02, 0, 1, 8'hFD, 8'h00, 32'hC0, 32'h300);
      vecs[15] = make_vec(0, 0, 0, 0,                 8'h00, 8'h00, 0, 1, 8'hFF, 8'h00, 32'h0,  32'h0);

      rst_i = 1'b1;
      drive_idle(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_frdy", {56'h0, fetch_rdy}, 64'hFF);
      check_output("reset_irdy", {56'h0, issue_rdy}, 64'h00);
      check_output("reset_instr", {32'h0, issue_instr}, 64'h0);
      check_output("reset_pc", {32'h0, issue_pc}, 64'h0);
      @(posedge clk); #1;
      rst_i = 1'b0;

      for (int r = 0; r < 16; r++) begin
         @(posedge clk); #1;
         apply_stimulus(vecs[r]);
         @(negedge clk);
         check_output($sformatf("vec%0d_frdy", r), {56'h0, fetch_rdy}, {56'h0, vecs[r].exp_frdy});
         check_output($sformatf("vec%0d_irdy", r), {56'h0, issue_rdy}, {56'h0, vecs[r].exp_irdy});
         check_output($sformatf("vec%0d_instr", r), {32'h0, issue_instr}, {32'h0, vecs[r].exp_instr});
         check_output($sformatf("vec%0d_pc", r), {32'h0, issue_pc}, {32'h0, vecs[r].exp_pc});
      end

      // Thread 2: hold one entry, then push+pop together so both pointers keep wrapping.
      @(posedge clk); #1;
      drive_push(2, 32'hE0, 32'h500, 0, 2);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         drive_push(2, 32'hE1 + 32'(i), 32'h504 + 32'(4 * i), 1, 2);
         @(negedge clk);
         check_output($sformatf("wrap%0d_irdy2", i), {63'h0, issue_rdy[2]}, 64'h1);
         check_output($sformatf("wrap%0d_frdy2", i), {63'h0, fetch_rdy[2]}, 64'h1);
         sb_pop_check(2);
      end
      @(posedge clk); #1;
      apply_stimulus(make_vec(0, 0, 0, 0, 8'h00, 8'h00, 1, 2, 0, 0, 0, 0));
      @(negedge clk);
      sb_pop_check(2);
      @(posedge clk); #1;
      drive_idle(2);
      @(negedge clk);
      check_output("wrap_drained_irdy", {56'h0, issue_rdy}, 64'h00);
      check_output("wrap_sb_empty", 64'(sb_q.size()), 64'h0);

      // Round-robin selector over all threads, first to completion.
      push_all(32'hD0);
      rr_pop(8);
      @(posedge clk); #1;
      drive_idle(0);
      @(negedge clk);
      check_output("rr_drained_irdy", {56'h0, issue_rdy}, 64'h00);
      check_output("rr_sb_empty", 64'(sb_q.size()), 64'h0);

      // Second round interrupted by reset.
      push_all(32'hF0);
      rr_pop(3);
      @(posedge clk); #1;
      drive_idle(0);
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      check_output("midrst_irdy", {56'h0, issue_rdy}, 64'h00);
      check_output("midrst_frdy", {56'h0, fetch_rdy}, 64'hFF);
      check_output("midrst_instr", {32'h0, issue_instr}, 64'h0);
      sb_q.delete();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
